uart_ins_loader: RTL and testbench
==================================

# uart_ins_loader

Serial instruction loader that drives the instruction-memory write port of the single-cycle MIPS core (`WE`, `W_Ins`). It receives a framed byte stream on a UART RX line (8N1, LSB first) and assembles big-endian 32-bit instruction words. It emits each word with a one-cycle `WE` pulse, in the order the fetch stage stores them. It also reports load progress and errors so the board can hold the core in reset until the program is in place.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `RXD`  in  1  UART receive line; idle high; asynchronous to `CLK`.
- `WE`  out  1  instruction write strobe; exactly one cycle per assembled word.
- `W_Ins`  out  32  instruction word; valid while `WE`=1 and held until the next word.
- `BUSY`  out  1  high from header accept until the last `WE`.
- `DONE`  out  1  high after the final word of a frame is written.
- `ERR`  out  1  sticky framing error flag.
- `WCNT`  out  16  number of words written in the current frame.

## Operation
- **Frame format:** header byte 0xA5, then word count N (16 bits, high byte first), then N×4 data bytes. Each word is sent MSB byte first.
- **RX front end:** `RXD` passes through a 2-flop synchronizer. A high-to-low edge in the receiver idle state starts a byte.
  - Start bit is re-sampled at CLKS_PER_BIT/2 (integer divide). If it is high there, this is a false start: abort and return to idle with no byte.
  - Data bits are then sampled every CLKS_PER_BIT cycles, LSB first, followed by the stop bit.
  - Stop bit = 1: a one-cycle internal byte strobe with the byte.
  - Stop bit = 0: a framing error.
- **Loader FSM states:** IDLE, CNT_HI, CNT_LO, WORD, DONE.
  - IDLE/DONE: byte 0xA5 → CNT_HI. Header accept sets `BUSY`=1 and clears `DONE`, `ERR` and `WCNT`. Any other byte is ignored.
  - CNT_HI: latch N[15:8] → CNT_LO.
  - CNT_LO: latch N[7:0]. If N=0, go to DONE (`BUSY`=0, `DONE`=1, no `WE`). Otherwise go to WORD with the byte index cleared.
  - WORD: shift the byte into a 32-bit assembly register (byte index 0..3).
    - On the 4th byte, `W_Ins` loads the assembled word and `WE` pulses.
    - `WCNT` increments in the same cycle as the `WE` pulse.
    - When `WCNT` reaches N: `BUSY`=0, `DONE`=1, and the FSM moves to DONE.
- **Framing error (any loader state):**
  - `ERR`=1, `BUSY`=0, FSM → IDLE.
  - The partial word is discarded, no `WE` is issued, and `WCNT` keeps its value.
  - A framing error in IDLE/DONE still sets `ERR`, and `DONE` is cleared.
- **Ordering guarantee:** bytes are processed strictly in arrival order. Because the receiver cannot deliver two bytes within CLKS_PER_BIT cycles, no internal FIFO is needed.
- **Arithmetic:** `WCNT` and N are 16 bits; N=65535 is legal and the counter does not wrap. The bit-timing counter is $clog2(CLKS_PER_BIT) bits wide.
- **Reset (`RST`=0, any time):** `WE`=0, `W_Ins`=0, `BUSY`=0, `DONE`=0, `ERR`=0, `WCNT`=0; both FSMs → idle; the synchronizer is preset high. Reset during a frame abandons it. After release the receiver waits for `RXD` high, then a falling edge.

## Timing
- Synchronizer latency is 2 cycles.
- The byte strobe occurs about 9.5×CLKS_PER_BIT + 2 cycles after the start-bit falling edge on `RXD`.
- `WE`, `W_Ins` and `WCNT` update on the cycle after the 4th byte's strobe, i.e. 1 cycle after the strobe.
- `DONE`/`BUSY` update in the same cycle as the last `WE`.
- `WE` is never high for 2 consecutive cycles. The minimum `WE` spacing is 4 byte times.
- `ERR`, `BUSY` and `DONE` update one cycle after the stop-bit sample.

## Test plan
- **Load two words** (CLKS_PER_BIT=8): send A5 00 02 20 08 00 05 AC 09 00 00 → two `WE` pulses with `W_Ins`=0x20080005 then 0xAC090000; `WCNT` 1 then 2; `DONE`=1 and `BUSY`=0 in the cycle of the 2nd `WE`.
- **Zero count:** send A5 00 00 → no `WE`; `DONE`=1 and `BUSY`=0 one cycle after the 3rd byte strobe; `WCNT`=0.
- **Garbage before header:** send 00 FF 3C, then A5 00 01 12 34 56 78 → garbage ignored; a single `WE` with 0x12345678.
- **Framing error:** send A5 00 02, one word, then a byte with stop bit 0 inside the 2nd word → `ERR`=1, `BUSY`=0, `WCNT`=1, no further `WE`. A following A5 header clears `ERR`.
- **False start:** a 3-cycle low glitch on `RXD` (CLKS_PER_BIT=8) → no byte strobe and no state change. The next valid frame loads correctly.
- **Reset mid-frame:** assert `RST`=0 after 2 data bytes of a word, then release and send a complete 1-word frame → all outputs 0 during reset; exactly one `WE` after release, carrying the new word.

Source files
------------

// File: rtl/uart_ins_loader.sv
// UART (8N1) instruction loader: parses an A5 / N(16) / N*4-byte frame and
// writes big-endian 32-bit words to the instruction memory with a WE pulse.
module uart_ins_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RXD,
    output logic        WE,
    output logic [31:0] W_Ins,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] WCNT
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    HDR       = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_CNT_HI, L_CNT_LO, L_WORD, L_DONE} ld_state_t;

    logic            rx_m, rx_s, rx_p;
    rx_state_t       rx_st;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_sh;
    logic [7:0]      rx_byte;
    logic            byte_stb;
    logic            frm_err;

    ld_state_t       ld_st;
    logic [7:0]      n_hi;
    logic [15:0]     n_words;
    logic [23:0]     asm_w;
    logic [1:0]      byte_idx;

    // Preset high so a line held idle after reset never looks like a start edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= RXD;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_st    <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
            case (rx_st)
                R_IDLE: begin
                    if (rx_p && !rx_s) begin
                        rx_st   <= R_START;
                        bit_cnt <= '0;
                    end
                end
                R_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        rx_st   <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        rx_sh   <= {rx_s, rx_sh[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_st <= R_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        rx_st   <= R_IDLE;
                        if (rx_s) begin
                            byte_stb <= 1'b1;
                            rx_byte  <= rx_sh;
                        end else begin
                            frm_err  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_st <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ld_st    <= L_IDLE;
            n_hi     <= '0;
            n_words  <= '0;
            asm_w    <= '0;
            byte_idx <= '0;
            WE       <= 1'b0;
            W_Ins    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            WCNT     <= '0;
        end else begin
            WE <= 1'b0;
            if (frm_err) begin
                // Any partial word is dropped; WCNT keeps what was already written
                ERR   <= 1'b1;
                BUSY  <= 1'b0;
                DONE  <= 1'b0;
                ld_st <= L_IDLE;
            end else if (byte_stb) begin
                case (ld_st)
                    L_IDLE, L_DONE: begin
                        if (rx_byte == HDR) begin
                            ld_st <= L_CNT_HI;
                            BUSY  <= 1'b1;
                            DONE  <= 1'b0;
                            ERR   <= 1'b0;
                            WCNT  <= '0;
                        end
                    end
                    L_CNT_HI: begin
                        n_hi  <= rx_byte;
                        ld_st <= L_CNT_LO;
                    end
                    L_CNT_LO: begin
                        n_words  <= {n_hi, rx_byte};
                        byte_idx <= '0;
                        if ({n_hi, rx_byte} == 16'd0) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            ld_st <= L_DONE;
                        end else begin
                            ld_st <= L_WORD;
                        end
                    end
                    L_WORD: begin
                        asm_w    <= {asm_w[15:0], rx_byte};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            W_Ins <= {asm_w, rx_byte};
                            WE    <= 1'b1;
                            WCNT  <= WCNT + 16'd1;
                            if (WCNT + 16'd1 == n_words) begin
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                                ld_st <= L_DONE;
                            end
                        end
                    end
                    default: ld_st <= L_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_ins_loader.sv
// Bench for uart_ins_loader: table of frames, hand-written corner sequences,
// and random frames checked against expectations derived from the frame layout.
module tb_uart_ins_loader;

    localparam int CPB = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RXD = 1'b1;
    logic        WE;
    logic [31:0] W_Ins;
    logic        BUSY, DONE, ERR;
    logic [15:0] WCNT;

    uart_ins_loader #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .RXD(RXD), .WE(WE), .W_Ins(W_Ins),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .WCNT(WCNT)
    );

    always #5 CLK = ~CLK;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    typedef struct {
        logic [31:0] w;
        logic [15:0] c;
        logic        done;
        logic        busy;
        logic        b2b;
    } ev_t;

    typedef struct {
        string        name;
        int           len;
        logic [127:0] b;      // bytes, first byte in the top 8 bits
        int           err_at; // index of byte sent with stop bit 0, -1 for none
        int           nwe;
        logic [1:0][31:0] w;  // w[0] is the first word written
        int           n_frame;
        logic         done, busy, err;
        logic [15:0]  wcnt;
    } vec_t;

    ev_t  ev_q[$];
    logic prev_we = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Record every write strobe as seen on the falling edge
    always @(negedge CLK) begin
        if (RST && WE)
            ev_q.push_back('{W_Ins, WCNT, DONE, BUSY, prev_we});
        prev_we <= WE;
    end

    task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = stop;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_reset();
        RXD = 1'b1;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        ev_q.delete();
    endtask

    task automatic check_events(input string tag, input wq_t exp_w, input int n_frame);
        chk(tag, "we_count", 32'(ev_q.size()), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < ev_q.size(); k++) begin
            chk(tag, $sformatf("W_Ins[%0d]", k), ev_q[k].w, exp_w[k]);
            chk(tag, $sformatf("WCNT_at_we[%0d]", k), 32'(ev_q[k].c), 32'(k + 1));
            chk(tag, $sformatf("DONE_at_we[%0d]", k), 32'(ev_q[k].done), 32'(k + 1 == n_frame));
            chk(tag, $sformatf("BUSY_at_we[%0d]", k), 32'(ev_q[k].busy), 32'(k + 1 != n_frame));
            chk(tag, $sformatf("we_back_to_back[%0d]", k), 32'(ev_q[k].b2b), 32'd0);
        end
    endtask

    task automatic run_case(input string tag, input bq_t bytes, input int err_at, input wq_t exp_w,
                            input int n_frame, input logic e_done, input logic e_busy,
                            input logic e_err, input logic [15:0] e_wcnt);
        do_reset();
        foreach (bytes[i]) send_byte(bytes[i], (i != err_at));
        repeat (4 * CPB) @(negedge CLK);
        check_events(tag, exp_w, n_frame);
        chk(tag, "DONE", 32'(DONE), 32'(e_done));
        chk(tag, "BUSY", 32'(BUSY), 32'(e_busy));
        chk(tag, "ERR",  32'(ERR),  32'(e_err));
        chk(tag, "WCNT", 32'(WCNT), 32'(e_wcnt));
    endtask

    vec_t tbl[7];

    initial begin
        bq_t  bq;
        wq_t  wq;
        int   g, n, p, errp, hdr, nw;
        logic [7:0] b;
        logic e_err;

        tbl[0] = '{"two_words", 11, {88'hA5_00_02_20_08_00_05_AC_09_00_00, 40'h0}, -1, 2,
                   {32'hAC090000, 32'h20080005}, 2, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[1] = '{"zero_cnt", 3, {24'hA5_00_00, 104'h0}, -1, 0,
                   {32'h0, 32'h0}, 0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[2] = '{"garbage", 10, {80'h00_FF_3C_A5_00_01_12_34_56_78, 48'h0}, -1, 1,
                   {32'h0, 32'h12345678}, 1, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[3] = '{"frame_err", 9, {72'hA5_00_02_11_22_33_44_55_66, 56'h0}, 8, 1,
                   {32'h0, 32'h11223344}, 2, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[4] = '{"err_then_hdr", 9, {72'hA5_00_02_11_22_33_44_55_A5, 56'h0}, 7, 1,
                   {32'h0, 32'h11223344}, 2, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[5] = '{"max_cnt", 7, {56'hA5_FF_FF_DE_AD_BE_EF, 72'h0}, -1, 1,
                   {32'h0, 32'hDEADBEEF}, 65535, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[6] = '{"err_in_done", 4, {32'hA5_00_00_77, 96'h0}, 3, 0,
                   {32'h0, 32'h0}, 0, 1'b0, 1'b0, 1'b1, 16'd0};

        // Reset state
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset", "WE", 32'(WE), 32'd0);
        chk("reset", "W_Ins", W_Ins, 32'd0);
        chk("reset", "BUSY", 32'(BUSY), 32'd0);
        chk("reset", "DONE", 32'(DONE), 32'd0);
        chk("reset", "ERR", 32'(ERR), 32'd0);
        chk("reset", "WCNT", 32'(WCNT), 32'd0);

        foreach (tbl[t]) begin
            bq.delete();
            wq.delete();
            for (int i = 0; i < tbl[t].len; i++) bq.push_back(tbl[t].b[127 - 8*i -: 8]);
            for (int k = 0; k < tbl[t].nwe; k++) wq.push_back(tbl[t].w[k]);
            run_case(tbl[t].name, bq, tbl[t].err_at, wq, tbl[t].n_frame,
                     tbl[t].done, tbl[t].busy, tbl[t].err, tbl[t].wcnt);
        end

        // False start: short low glitch mid-frame changes nothing
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        RXD = 1'b0;
        repeat (3) @(negedge CLK);
        RXD = 1'b1;
        repeat (3 * CPB) @(negedge CLK);
        chk("false_start", "BUSY", 32'(BUSY), 32'd1);
        chk("false_start", "ERR", 32'(ERR), 32'd0);
        chk("false_start", "WCNT", 32'(WCNT), 32'd0);
        chk("false_start", "we_count", 32'(ev_q.size()), 32'd0);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'hBA, 1'b1);
        send_byte(8'hBE, 1'b1);
        repeat (4 * CPB) @(negedge CLK);
        wq.delete();
        wq.push_back(32'hCAFEBABE);
        check_events("false_start", wq, 1);
        chk("false_start", "DONE_end", 32'(DONE), 32'd1);

        // Reset in the middle of the second word of a frame
        do_reset();
        bq = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        chk("reset_mid", "BUSY_before", 32'(BUSY), 32'd1);
        chk("reset_mid", "W_Ins_before", W_Ins, 32'h11223344);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_mid", "WE", 32'(WE), 32'd0);
        chk("reset_mid", "W_Ins", W_Ins, 32'd0);
        chk("reset_mid", "BUSY", 32'(BUSY), 32'd0);
        chk("reset_mid", "DONE", 32'(DONE), 32'd0);
        chk("reset_mid", "ERR", 32'(ERR), 32'd0);
        chk("reset_mid", "WCNT", 32'(WCNT), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        ev_q.delete();
        bq = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (bq[i]) send_byte(bq[i], 1'b1);
        repeat (4 * CPB) @(negedge CLK);
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        check_events("reset_mid", wq, 1);
        chk("reset_mid", "DONE_end", 32'(DONE), 32'd1);
        chk("reset_mid", "WCNT_end", 32'(WCNT), 32'd1);

        // Random frames: garbage, header, N words, optional framing error
        for (int it = 0; it < 20; it++) begin
            bq.delete();
            wq.delete();
            errp = -1;
            e_err = 1'b0;
            g = int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                bq.push_back(b);
            end
            if (g > 0 && $urandom_range(0, 3) == 0) errp = int'($urandom_range(0, g - 1));
            hdr = bq.size();
            n = int'($urandom_range(1, 3));
            bq.push_back(8'hA5);
            bq.push_back(8'h00);
            bq.push_back(8'(n));
            for (int j = 0; j < 4 * n; j++) bq.push_back(8'($urandom));
            nw = n;
            if (errp < 0 && $urandom_range(0, 2) == 0) begin
                p = int'($urandom_range(0, 4 * n - 1));
                errp = hdr + 3 + p;
                nw = p / 4;
                bq = bq[0:errp];
                e_err = 1'b1;
            end
            for (int k = 0; k < nw; k++)
                wq.push_back({bq[hdr+3+4*k], bq[hdr+4+4*k], bq[hdr+5+4*k], bq[hdr+6+4*k]});
            run_case($sformatf("rand%0d", it), bq, errp, wq, n,
                     !e_err, 1'b0, e_err, 16'(nw));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
